// File: rtl/sll_seq.sv
// sll_seq: multi-cycle logical-shift-left / rotate-left unit.
// Shifts one bit per clock under a START/BUSY/DONE handshake and holds the
// last result on OUTPUT until the next completion.
module sll_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] IN,
  input  logic [7:0]       SHIFT,
  input  logic             ROTATE,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned LOG_W = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rot;
  logic [WIDTH-1:0] r_output;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_cnt_load;
  logic [WIDTH-1:0] w_data_shl;

  // Effective count: rotate wraps modulo WIDTH, logical clamps at WIDTH
  assign w_cnt_load = ROTATE ? CNT_W'(SHIFT[LOG_W-1:0]) :
                      (32'(SHIFT) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(SHIFT);

  // One-bit left step; the vacated LSB takes the old MSB only when rotating
  assign w_data_shl = {r_data[WIDTH-2:0], r_rot & r_data[WIDTH-1]};

  // Control FSM with datapath and registered handshake outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_rot    <= 1'b0;
      r_output <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_data  <= IN;
            r_rot   <= ROTATE;
            r_cnt   <= w_cnt_load;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_data <= w_data_shl;
            r_cnt  <= r_cnt - CNT_W'(1);
          end else begin
            r_output <= r_data;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign OUTPUT = r_output;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_sll_seq.sv
// Directed testbench for sll_seq (WIDTH=8).
module tb_sll_seq;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] IN;
  logic [7:0] SHIFT;
  logic       ROTATE;
  logic [7:0] OUTPUT;
  logic       BUSY;
  logic       DONE;

  int checks;
  int failures;

  sll_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .IN     (IN),
    .SHIFT  (SHIFT),
    .ROTATE (ROTATE),
    .OUTPUT (OUTPUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issue one operation and wait for DONE. lat = edges after capture edge
  // until DONE is seen (-1 on timeout); busy_n = samples with BUSY high;
  // overlap set if BUSY and DONE were ever high together.
  task automatic run_op(input logic [7:0] a, input logic [7:0] sh, input logic rot,
                        output int lat, output int busy_n, output bit overlap);
    lat = -1; busy_n = 0; overlap = 1'b0;
    @(negedge CLK);
    IN = a; SHIFT = sh; ROTATE = rot; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    if (BUSY) busy_n++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (BUSY) busy_n++;
      if (BUSY && DONE) overlap = 1'b1;
      if (DONE) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b0; IN = 8'h00; SHIFT = 8'h00; ROTATE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (OUTPUT !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b, want 00/0/0", OUTPUT, BUSY, DONE);
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0/0", BUSY, DONE);
    end
  endtask

  task automatic test_logical();
    int lat, bn; bit ov;
    run_op(8'h96, 8'd3, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 4 || OUTPUT !== 8'hB0) begin
      failures++;
      $display("FAIL logical_sh3: got lat=%0d out=%h, want lat=4 out=b0", lat, OUTPUT);
    end
    checks++;
    if (bn !== 4 || ov) begin
      failures++;
      $display("FAIL logical_busy: got busy_cycles=%0d overlap=%b, want 4/0", bn, ov);
    end
    // DONE is a single pulse and OUTPUT holds while idle
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || OUTPUT !== 8'hB0) begin
      failures++;
      $display("FAIL done_pulse_hold: got done=%b busy=%b out=%h, want 0/0/b0", DONE, BUSY, OUTPUT);
    end
  endtask

  task automatic test_rotate();
    int lat, bn; bit ov;
    run_op(8'h96, 8'd3, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 4 || OUTPUT !== 8'hB4) begin
      failures++;
      $display("FAIL rotate_sh3: got lat=%0d out=%h, want lat=4 out=b4", lat, OUTPUT);
    end
    run_op(8'h96, 8'h0B, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 4 || OUTPUT !== 8'hB4) begin
      failures++;
      $display("FAIL rotate_sh11: got lat=%0d out=%h, want lat=4 out=b4", lat, OUTPUT);
    end
    run_op(8'h81, 8'd1, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 2 || OUTPUT !== 8'h03) begin
      failures++;
      $display("FAIL rotate_msb_wrap: got lat=%0d out=%h, want lat=2 out=03", lat, OUTPUT);
    end
  endtask

  task automatic test_boundary();
    int lat, bn; bit ov;
    run_op(8'hFF, 8'h0C, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 9 || OUTPUT !== 8'h00 || bn !== 9) begin
      failures++;
      $display("FAIL logical_clamp12: got lat=%0d out=%h busy=%0d, want 9/00/9", lat, OUTPUT, bn);
    end
    run_op(8'h5A, 8'd0, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 1 || OUTPUT !== 8'h5A) begin
      failures++;
      $display("FAIL logical_sh0: got lat=%0d out=%h, want lat=1 out=5a", lat, OUTPUT);
    end
    run_op(8'hA5, 8'd0, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 1 || OUTPUT !== 8'hA5) begin
      failures++;
      $display("FAIL rotate_sh0: got lat=%0d out=%h, want lat=1 out=a5", lat, OUTPUT);
    end
    run_op(8'h3C, 8'd8, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 1 || OUTPUT !== 8'h3C) begin
      failures++;
      $display("FAIL rotate_sh8: got lat=%0d out=%h, want lat=1 out=3c", lat, OUTPUT);
    end
    run_op(8'h81, 8'd7, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 8 || OUTPUT !== 8'h80) begin
      failures++;
      $display("FAIL logical_sh7: got lat=%0d out=%h, want lat=8 out=80", lat, OUTPUT);
    end
    run_op(8'hC3, 8'hFF, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 9 || OUTPUT !== 8'h00) begin
      failures++;
      $display("FAIL logical_sh255: got lat=%0d out=%h, want lat=9 out=00", lat, OUTPUT);
    end
  endtask

  task automatic test_handshake();
    int lat;
    // First op, then disturb START/operands while busy
    @(negedge CLK);
    IN = 8'h96; SHIFT = 8'd3; ROTATE = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    IN = 8'hFF; SHIFT = 8'd1; ROTATE = 1'b1; START = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 4 || OUTPUT !== 8'hB0) begin
      failures++;
      $display("FAIL busy_ignore: got lat=%0d out=%h, want lat=4 out=b0", lat, OUTPUT);
    end
    // Back-to-back: START on the DONE cycle
    @(negedge CLK);
    IN = 8'h01; SHIFT = 8'd7; ROTATE = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || OUTPUT !== 8'hB0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b out=%h, want 1/0/b0", BUSY, DONE, OUTPUT);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 8 || OUTPUT !== 8'h80) begin
      failures++;
      $display("FAIL b2b_result: got lat=%0d out=%h, want lat=8 out=80", lat, OUTPUT);
    end
    // Immediate back-to-back via run_op, which asserts START on this DONE cycle
    begin
      int l2, bn; bit ov;
      run_op(8'h11, 8'd2, 1'b1, l2, bn, ov);
      checks++;
      if (l2 !== 3 || OUTPUT !== 8'h44 || ov) begin
        failures++;
        $display("FAIL b2b_rotate: got lat=%0d out=%h ov=%b, want 3/44/0", l2, OUTPUT, ov);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bn; bit ov;
    @(negedge CLK);
    IN = 8'h96; SHIFT = 8'd5; ROTATE = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++;
    if (OUTPUT !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got out=%h busy=%b done=%b, want 00/0/0", OUTPUT, BUSY, DONE);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    bn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) bn++;
    end
    checks++;
    if (bn !== 0 || OUTPUT !== 8'h00) begin
      failures++;
      $display("FAIL reset_abort: got activity=%0d out=%h, want 0/00", bn, OUTPUT);
    end
    run_op(8'h03, 8'd1, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 2 || OUTPUT !== 8'h06) begin
      failures++;
      $display("FAIL post_reset_op: got lat=%0d out=%h, want lat=2 out=06", lat, OUTPUT);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_logical();
    test_rotate();
    test_boundary();
    test_handshake();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
